// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, reset/bubble constants and
// the IF/ID pipeline register layout.
package instruction_fetch_unit_pkg;

    localparam int                    DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = 32'd4;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instruction;
        logic                  valid;
    } if_id_t;

    // Contents of IF/ID after reset or a flush: an addi x0,x0,0 marked invalid.
    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR, valid: 1'b0};

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: control from hazard/branch logic, memory read path and the
// IF/ID outputs toward decode.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    // No valid/ready handshake: stall_i and redirect_i are sampled on every
    // rising edge, redirect_i wins over stall_i, and all outputs are registered.
    logic                  stall_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_target_i;
    logic [DATA_WIDTH-1:0] instruction_i;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] if_id_pc_o;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_o;
    logic [DATA_WIDTH-1:0] if_id_instruction_o;
    logic                  if_id_valid_o;
    logic                  misaligned_o;
    logic [DATA_WIDTH-1:0] fetch_count_o;

    modport master (
        output stall_i, redirect_i, redirect_target_i, instruction_i,
        input  pc_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instruction_o,
               if_id_valid_o, misaligned_o, fetch_count_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_target_i, instruction_i,
        output pc_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instruction_o,
               if_id_valid_o, misaligned_o, fetch_count_o
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register with hold and flush; flush takes priority over hold.
module instruction_fetch_unit_if_id_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage top: PC register with next-PC selection, fetch counter,
// misaligned-target pulse and the IF/ID register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    // Counter value loaded on reset; nonzero only to exercise counter wrap.
    parameter logic [DATA_WIDTH-1:0] COUNT_RESET = '0
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.slave  bus
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] count_q;
    logic                  misaligned_q;
    if_id_t                if_id_d;
    if_id_t                if_id_q;

    assign pc_plus4 = pc_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            count_q      <= COUNT_RESET;
            misaligned_q <= 1'b0;
        end else if (bus.redirect_i) begin
            pc_q         <= word_align(bus.redirect_target_i);
            misaligned_q <= |bus.redirect_target_i[1:0];
        end else begin
            misaligned_q <= 1'b0;
            if (!bus.stall_i) begin
                pc_q    <= pc_plus4;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign if_id_d = '{pc: pc_q, pc_plus4: pc_plus4, instruction: bus.instruction_i, valid: 1'b1};

    instruction_fetch_unit_if_id_register u_if_id (
        .clk   (clk),
        .reset (reset),
        .hold  (bus.stall_i),
        .flush (bus.redirect_i),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign bus.pc_o                = pc_q;
    assign bus.if_id_pc_o          = if_id_q.pc;
    assign bus.if_id_pc_plus4_o    = if_id_q.pc_plus4;
    assign bus.if_id_instruction_o = if_id_q.instruction;
    assign bus.if_id_valid_o       = if_id_q.valid;
    assign bus.misaligned_o        = misaligned_q;
    assign bus.fetch_count_o       = count_q;

endmodule
